// File: rtl/mac_result_accumulator_pkg.sv
// Shared types and parameter sanity helpers for the mac result accumulator.
// State encodings are fixed so benches and probes can decode them directly.
package mac_result_accumulator_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } acc_state_e;

  function automatic bit params_ok(int unsigned in_width, int unsigned acc_width,
                                   int unsigned vec_len);
    return (acc_width >= in_width) && (vec_len >= 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Unsigned saturating adder: ACC_WIDTH accumulator plus IN_WIDTH addend,
// clamped to all-ones on carry-out, with the carry reported as overflow.
module mac_sat_add #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [IN_WIDTH-1:0]  add_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH:0] raw_sum;

  // ACC_WIDTH >= IN_WIDTH, so a single carry bit captures every overflow.
  always_comb begin
    raw_sum = {1'b0, acc_i} + (ACC_WIDTH + 1)'(add_i);
    ovf_o   = raw_sum[ACC_WIDTH];
    sum_o   = ovf_o ? {ACC_WIDTH{1'b1}} : raw_sum[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/mac_result_accumulator.sv
// Sums VEC_LEN mac results into one saturating dot-product term and holds it
// on a registered valid/ready output until the consumer takes it.
module mac_result_accumulator
  import mac_result_accumulator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned VEC_LEN   = 4,
  localparam int unsigned CNT_WIDTH = $clog2(VEC_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  if (!params_ok(IN_WIDTH, ACC_WIDTH, VEC_LEN)) begin : g_bad_params
    $error("mac_result_accumulator: need ACC_WIDTH >= IN_WIDTH and VEC_LEN >= 1");
  end

  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(VEC_LEN - 1);
  localparam bit SingleBeat = (VEC_LEN == 1);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sat_q, out_sat_d;

  logic                 accept;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] in_data_ext;

  assign in_ready    = (state_q != StHold) && !clear;
  assign accept      = in_valid && in_ready;
  assign in_data_ext = ACC_WIDTH'(in_data);

  mac_sat_add #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .acc_i (acc_q),
    .add_i (in_data),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;

    if (clear) begin
      // Abort drops the partial vector and any pending result; out_data is kept.
      state_d     = StIdle;
      acc_d       = '0;
      sat_d       = 1'b0;
      beat_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d      = in_data_ext;
            sat_d      = 1'b0;
            beat_cnt_d = CNT_WIDTH'(1);
            if (SingleBeat) begin
              out_data_d  = in_data_ext;
              out_sat_d   = 1'b0;
              out_valid_d = 1'b1;
              beat_cnt_d  = '0;
              state_d     = StHold;
            end else begin
              state_d = StAccum;
            end
          end
        end

        StAccum: begin
          if (accept) begin
            acc_d      = add_sum;
            sat_d      = sat_q | add_ovf;
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            if (beat_cnt_q == LastBeat) begin
              out_data_d  = add_sum;
              out_sat_d   = sat_q | add_ovf;
              out_valid_d = 1'b1;
              beat_cnt_d  = '0;
              state_d     = StHold;
            end
          end
        end

        StHold: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            state_d     = StIdle;
          end
        end

        default: begin
          state_d     = StIdle;
          acc_d       = '0;
          sat_d       = 1'b0;
          beat_cnt_d  = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed bench for mac_result_accumulator: a 12-bit and a 9-bit accumulator
// share one stimulus stream so saturation can be observed on the narrow one.
module tb_mac_result_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        clear;
  logic        out_ready;

  logic        in_ready;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_sat;
  logic [2:0]  beat_cnt;

  logic        d9_in_ready;
  logic [8:0]  d9_out_data;
  logic        d9_out_valid;
  logic        d9_out_sat;
  logic [2:0]  d9_beat_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mac_result_accumulator #(
    .IN_WIDTH  (8),
    .ACC_WIDTH (12),
    .VEC_LEN   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .beat_cnt  (beat_cnt)
  );

  mac_result_accumulator #(
    .IN_WIDTH  (8),
    .ACC_WIDTH (9),
    .VEC_LEN   (4)
  ) dut9 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (d9_in_ready),
    .clear     (clear),
    .out_data  (d9_out_data),
    .out_valid (d9_out_valid),
    .out_ready (out_ready),
    .out_sat   (d9_out_sat),
    .beat_cnt  (d9_beat_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] v [4];
    v = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++;
      $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 12'h000) begin n_miss++;
      $display("FAIL reset_out_data got %h want 000", out_data); end
    n_vec++; if (beat_cnt !== 3'd0) begin n_miss++;
      $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++;
      $display("FAIL reset_in_ready got %b want 1", in_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [4];
    v = '{8'h16, 8'h43, 8'h7A, 8'hF0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++;
        $display("FAIL b2b_in_ready beat %0d got %b want 1", i, in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_miss++;
        $display("FAIL b2b_early_valid beat %0d got %b want 0", i, out_valid); end
      tick();
      n_vec++; if (beat_cnt !== ((i == 3) ? 3'd0 : 3'(i + 1))) begin n_miss++;
        $display("FAIL b2b_beat_cnt beat %0d got %0d want %0d", i, beat_cnt,
                 (i == 3) ? 0 : i + 1); end
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_miss++;
      $display("FAIL b2b_out_valid got %b want 1", out_valid); end
    n_vec++; if (out_data !== 12'h1C3) begin n_miss++;
      $display("FAIL b2b_out_data got %h want 1c3", out_data); end
    n_vec++; if (out_sat !== 1'b0) begin n_miss++;
      $display("FAIL b2b_out_sat got %b want 0", out_sat); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++;
      $display("FAIL b2b_valid_one_cycle got %b want 0", out_valid); end
    n_vec++; if (out_data !== 12'h1C3) begin n_miss++;
      $display("FAIL b2b_data_retained got %h want 1c3", out_data); end
  endtask

  task automatic test_gaps();
    logic [7:0] v [4];
    v = '{8'h16, 8'h43, 8'h7A, 8'hF0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
      in_valid = 1'b0;
      if (i < 3) begin
        n_vec++; if (beat_cnt !== 3'(i + 1)) begin n_miss++;
          $display("FAIL gap_beat_cnt beat %0d got %0d want %0d", i, beat_cnt, i + 1); end
        tick();
        tick();
        n_vec++; if (beat_cnt !== 3'(i + 1) || out_valid !== 1'b0) begin n_miss++;
          $display("FAIL gap_hold beat %0d got cnt %0d valid %b want cnt %0d valid 0",
                   i, beat_cnt, out_valid, i + 1); end
      end
    end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h1C3) begin n_miss++;
      $display("FAIL gap_result got valid %b data %h want valid 1 data 1c3",
               out_valid, out_data); end
    tick();
  endtask

  task automatic test_hold_backpressure();
    out_ready = 1'b0;
    send_vec(8'h16, 8'h43, 8'h7A, 8'hF0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_miss++;
        $display("FAIL hold_in_ready cycle %0d got %b want 0", c, in_ready); end
      n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h1C3) begin n_miss++;
        $display("FAIL hold_stable cycle %0d got valid %b data %h want valid 1 data 1c3",
                 c, out_valid, out_data); end
      tick();
    end
    n_vec++; if (beat_cnt !== 3'd0) begin n_miss++;
      $display("FAIL hold_no_beats got %0d want 0", beat_cnt); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++;
      $display("FAIL hold_release got %b want 0", out_valid); end
    send_vec(8'd1, 8'd2, 8'd3, 8'd4);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h00A) begin n_miss++;
      $display("FAIL hold_next_vec got valid %b data %h want valid 1 data 00a",
               out_valid, out_data); end
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    send_vec(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    n_vec++; if (d9_out_data !== 9'h1FF || d9_out_sat !== 1'b1) begin n_miss++;
      $display("FAIL sat9_clamp got data %h sat %b want data 1ff sat 1",
               d9_out_data, d9_out_sat); end
    n_vec++; if (out_data !== 12'h3FC || out_sat !== 1'b0) begin n_miss++;
      $display("FAIL sat12_wide got data %h sat %b want data 3fc sat 0", out_data, out_sat); end
    out_ready = 1'b1;
    tick();
    send_vec(8'd1, 8'd1, 8'd1, 8'd1);
    n_vec++; if (d9_out_data !== 9'h004 || d9_out_sat !== 1'b0 || d9_out_valid !== 1'b1)
      begin n_miss++;
      $display("FAIL sat9_recover got data %h sat %b valid %b want data 004 sat 0 valid 1",
               d9_out_data, d9_out_sat, d9_out_valid); end
    tick();
  endtask

  task automatic test_clear_and_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd5; tick();
    in_data = 8'd6; tick();
    n_vec++; if (beat_cnt !== 3'd2) begin n_miss++;
      $display("FAIL clr_pre_cnt got %0d want 2", beat_cnt); end
    clear   = 1'b1;
    in_data = 8'h77;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_miss++;
      $display("FAIL clr_in_ready got %b want 0", in_ready); end
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (beat_cnt !== 3'd0 || out_valid !== 1'b0) begin n_miss++;
      $display("FAIL clr_state got cnt %0d valid %b want cnt 0 valid 0", beat_cnt, out_valid); end
    send_vec(8'd1, 8'd2, 8'd3, 8'd4);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h00A) begin n_miss++;
      $display("FAIL clr_next_vec got valid %b data %h want valid 1 data 00a",
               out_valid, out_data); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || out_data !== 12'h000 || beat_cnt !== 3'd0) begin
      n_miss++;
      $display("FAIL rst_in_hold got valid %b data %h cnt %0d want valid 0 data 000 cnt 0",
               out_valid, out_data, beat_cnt); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_hold_backpressure();
    test_saturation();
    test_clear_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
